// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Sequences the board rPLL from the free-running 27 MHz input clock: holds the PLL in
//   reset, waits for LOCK, requires LOCK to stay high for a qualification window, then
//   releases the system reset. Lock timeouts are retried a bounded number of times
//   before parking in FAULT until an explicit retry pulse.
//   o_sys_rst_n must be re-synchronised by every PLL-output clock domain that uses it.
//
// Ports
//   clk              in   27 MHz board clock (never the PLL output)
//   rst_n            in   asynchronous active-low reset
//   i_pll_lock       in   rPLL LOCK, asynchronous, 2-FF synchronised here
//   i_retry          in   1-cycle pulse, leaves FAULT, ignored elsewhere
//   o_pll_reset      out  rPLL RESET, active high
//   o_sys_rst_n      out  system reset, active low, high only in RUN
//   o_locked_ok      out  high only in RUN
//   o_fault          out  high only in FAULT
//   o_state          out  current state encoding (debug)
//   o_relock_count   out  RUN lock-loss events, saturating at 255

module pll_lock_supervisor #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 27000,
    parameter int unsigned STABLE_CYCLES = 2700,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_pll_lock,
    input  logic       i_retry,
    output logic       o_pll_reset,
    output logic       o_sys_rst_n,
    output logic       o_locked_ok,
    output logic       o_fault,
    output logic [2:0] o_state,
    output logic [7:0] o_relock_count
);

    localparam int unsigned RetryW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0]  RstLast    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LockLast   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  StableLast = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CntOne     = CNT_W'(1);
    localparam logic [RetryW-1:0] RetryMax   = RetryW'(MAX_RETRY);
    localparam logic [RetryW-1:0] RetryOne   = RetryW'(1);

    typedef enum logic [2:0] {
        StPllRst   = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRun      = 3'd3,
        StFault    = 3'd4
    } state_e;

    state_e              r_state;
    state_e              w_state_d;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_d;
    logic [RetryW-1:0]   r_retry_cnt;
    logic [RetryW-1:0]   w_retry_d;
    logic [RetryW-1:0]   w_retry_inc;
    logic [7:0]          r_relock;
    logic [7:0]          w_relock_d;
    logic                r_lock_s1;
    logic                r_lock_s2;
    logic                r_pll_reset;
    logic                r_sys_rst_n;
    logic                r_locked_ok;
    logic                r_fault;

    assign w_retry_inc = r_retry_cnt + RetryOne;

    always_comb begin
        w_state_d  = r_state;
        w_retry_d  = r_retry_cnt;
        w_relock_d = r_relock;
        case (r_state)
            StPllRst: begin
                if (r_cnt == RstLast) w_state_d = StWaitLock;
            end
            StWaitLock: begin
                // Lock takes priority over a timeout landing on the same cycle.
                if (r_lock_s2) begin
                    w_state_d = StStable;
                end else if (r_cnt == LockLast) begin
                    w_retry_d = w_retry_inc;
                    w_state_d = (w_retry_inc == RetryMax) ? StFault : StPllRst;
                end
            end
            StStable: begin
                // A glitch sends us back to wait for lock without charging a retry.
                if (!r_lock_s2) begin
                    w_state_d = StWaitLock;
                end else if (r_cnt == StableLast) begin
                    w_state_d = StRun;
                    w_retry_d = '0;
                end
            end
            StRun: begin
                if (!r_lock_s2) begin
                    w_state_d = StPllRst;
                    if (r_relock != 8'hFF) w_relock_d = r_relock + 8'd1;
                end
            end
            StFault: begin
                if (i_retry) begin
                    w_state_d = StPllRst;
                    w_retry_d = '0;
                end
            end
            default: w_state_d = StPllRst;
        endcase
        w_cnt_d = (w_state_d != r_state) ? '0 : r_cnt + CntOne;
    end

    // Outputs are registered from the next state so they always decode the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StPllRst;
            r_cnt       <= '0;
            r_retry_cnt <= '0;
            r_relock    <= '0;
            r_lock_s1   <= 1'b0;
            r_lock_s2   <= 1'b0;
            r_pll_reset <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_locked_ok <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_retry_cnt <= w_retry_d;
            r_relock    <= w_relock_d;
            r_lock_s1   <= i_pll_lock;
            r_lock_s2   <= r_lock_s1;
            r_pll_reset <= (w_state_d == StPllRst) || (w_state_d == StFault);
            r_sys_rst_n <= (w_state_d == StRun);
            r_locked_ok <= (w_state_d == StRun);
            r_fault     <= (w_state_d == StFault);
        end
    end

    assign o_pll_reset    = r_pll_reset;
    assign o_sys_rst_n    = r_sys_rst_n;
    assign o_locked_ok    = r_locked_ok;
    assign o_fault        = r_fault;
    assign o_state        = r_state;
    assign o_relock_count = r_relock;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor
//   Scoreboard bench for pll_lock_supervisor with small timing parameters.
//   Stimulus queues the expected state transitions (new state, cycles spent in the
//   previous state, outputs, relock count); a negedge monitor pops one entry per
//   observed state change and compares.

`timescale 1ns/1ps

module tb_pll_lock_supervisor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_lock;
    logic       retry;
    logic       pll_reset;
    logic       sys_rst_n;
    logic       locked_ok;
    logic       fault;
    logic [2:0] state;
    logic [7:0] relock_count;

    pll_lock_supervisor #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(10),
        .MAX_RETRY    (2),
        .CNT_W        (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_pll_lock    (pll_lock),
        .i_retry       (retry),
        .o_pll_reset   (pll_reset),
        .o_sys_rst_n   (sys_rst_n),
        .o_locked_ok   (locked_ok),
        .o_fault       (fault),
        .o_state       (state),
        .o_relock_count(relock_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] st;
        int         dw;
        logic       prst;
        logic       srst;
        logic       lok;
        logic       flt;
        logic [7:0] rc;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    int         checks   = 0;
    int         errors   = 0;
    int         ncyc     = 0;
    int         last_chg = 0;
    int         exp_rc   = 0;
    logic [2:0] prev_st  = 3'd0;
    logic [14:0] mon_got;
    logic [14:0] mon_req;

    // Queue one expected transition into state st after dw cycles in the previous state.
    task automatic expect_tr(input logic [2:0] st, input int dw);
        exp_t e;
        e.st   = st;
        e.dw   = dw;
        e.prst = (st == 3'd0) || (st == 3'd4);
        e.srst = (st == 3'd3);
        e.lok  = (st == 3'd3);
        e.flt  = (st == 3'd4);
        e.rc   = (exp_rc > 255) ? 8'd255 : 8'(exp_rc);
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Wait (bounded) until every queued transition has been observed.
    task automatic drain();
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (q.size() != 0 && n < 200);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0 state=%0d", q.size(), state);
            q.delete();
        end
    endtask

    task automatic check_reset(input string tag);
        logic [14:0] got;
        got = {state, pll_reset, sys_rst_n, locked_ok, fault, relock_count};
        checks++;
        if (got !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL reset_%s got st/prst/srst/lok/flt/rc=%0d/%b/%b/%b/%b/%0d required 0/1/0/0/0/0",
                     tag, state, pll_reset, sys_rst_n, locked_ok, fault, relock_count);
        end
    endtask

    // Monitor: every state change must match the head of the scoreboard.
    always @(negedge clk) begin
        ncyc++;
        if (!rst_n) begin
            prev_st  = 3'd0;
            last_chg = ncyc;
        end else if (state != prev_st) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_transition got %0d->%0d required none", prev_st, state);
            end else begin
                mon_e   = q.pop_front();
                mon_got = {state, pll_reset, sys_rst_n, locked_ok, fault, relock_count};
                mon_req = {mon_e.st, mon_e.prst, mon_e.srst, mon_e.lok, mon_e.flt, mon_e.rc};
                checks++;
                if (mon_got !== mon_req) begin
                    errors++;
                    $display("FAIL trans_outputs from %0d got st/prst/srst/lok/flt/rc=%0d/%b/%b/%b/%b/%0d required %0d/%b/%b/%b/%b/%0d",
                             prev_st, state, pll_reset, sys_rst_n, locked_ok, fault, relock_count,
                             mon_e.st, mon_e.prst, mon_e.srst, mon_e.lok, mon_e.flt, mon_e.rc);
                end
                checks++;
                if (ncyc - last_chg != mon_e.dw) begin
                    errors++;
                    $display("FAIL dwell %0d->%0d got %0d cycles required %0d",
                             prev_st, state, ncyc - last_chg, mon_e.dw);
                end
            end
            prev_st  = state;
            last_chg = ncyc;
        end
    end

    initial begin
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        retry    = 1'b0;
        tick(3);
        check_reset("initial");

        // 1: lock present from release.
        pll_lock = 1'b1;
        rst_n    = 1'b1;
        expect_tr(3'd1, 4);
        expect_tr(3'd2, 1);
        expect_tr(3'd3, 10);
        drain();

        // 3: lose lock in RUN; 3 edges from raw fall to leaving RUN.
        pll_lock = 1'b0;
        exp_rc   = 1;
        expect_tr(3'd0, 3);
        expect_tr(3'd1, 4);
        drain();
        pll_lock = 1'b1;
        expect_tr(3'd2, 3);
        drain();

        // 2: one-cycle lock drop seen at STABLE cnt=5.
        tick(3);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        expect_tr(3'd1, 6);
        expect_tr(3'd2, 1);
        expect_tr(3'd3, 10);
        drain();

        // 4: two timeouts then FAULT; lock ignored in FAULT; retry restarts.
        pll_lock = 1'b0;
        exp_rc   = 2;
        expect_tr(3'd0, 3);
        expect_tr(3'd1, 4);
        expect_tr(3'd0, 20);
        expect_tr(3'd1, 4);
        expect_tr(3'd4, 20);
        drain();
        expect_tr(3'd0, 6);
        expect_tr(3'd1, 4);
        expect_tr(3'd0, 20);
        expect_tr(3'd1, 4);
        pll_lock = 1'b1;
        tick(2);
        pll_lock = 1'b0;
        tick(3);
        retry = 1'b1;
        tick(1);
        retry = 1'b0;
        drain();
        pll_lock = 1'b1;
        expect_tr(3'd2, 3);
        expect_tr(3'd3, 10);
        drain();
        // RUN entry clears the retry count, so one timeout must not fault.
        pll_lock = 1'b0;
        exp_rc   = 3;
        expect_tr(3'd0, 3);
        expect_tr(3'd1, 4);
        expect_tr(3'd0, 20);
        expect_tr(3'd1, 4);
        drain();
        pll_lock = 1'b1;
        expect_tr(3'd2, 3);
        expect_tr(3'd3, 10);
        drain();

        // 5: relock counter saturation.
        for (int i = 0; i < 260; i++) begin
            pll_lock = 1'b0;
            exp_rc++;
            expect_tr(3'd0, 3);
            expect_tr(3'd1, 4);
            drain();
            pll_lock = 1'b1;
            expect_tr(3'd2, 3);
            expect_tr(3'd3, 10);
            drain();
        end

        // 6: asynchronous reset in RUN and in STABLE.
        tick(2);
        rst_n = 1'b0;
        #1;
        check_reset("in_run");
        tick(2);
        rst_n  = 1'b1;
        exp_rc = 0;
        expect_tr(3'd1, 4);
        expect_tr(3'd2, 1);
        drain();
        tick(3);
        rst_n = 1'b0;
        #1;
        check_reset("in_stable");
        tick(2);
        rst_n = 1'b1;
        expect_tr(3'd1, 4);
        expect_tr(3'd2, 1);
        expect_tr(3'd3, 10);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
